// File: rtl/telemetre_trigger_pkg.sv
// Shared definitions for the ultrasonic range-finder measurement sequencer:
// FSM encoding, 50 MHz default timing constants and counter sizing helper.
package telemetre_trigger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  // Number of bits needed to represent values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(max_val)) w++;
    return w;
  endfunction

  localparam int unsigned DEF_TRIG_CYCLES    = 500;        // 10 us
  localparam int unsigned DEF_PERIOD_CYCLES  = 3_000_000;  // 60 ms
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1_900_000;  // 38 ms
  localparam int unsigned DEF_CNT_W          = cnt_width(DEF_PERIOD_CYCLES);

endpackage

// File: rtl/telemetre_trigger_if.sv
// Sensor-side and downstream signals of the measurement sequencer.
interface telemetre_trigger_if;
  logic Enable;
  logic Echo;
  logic Trig;
  logic Gate;
  logic Done;
  logic TimeoutErr;
  logic Busy;

  modport master (
    output Enable, Echo,
    input  Trig, Gate, Done, TimeoutErr, Busy
  );

  modport slave (
    input  Enable, Echo,
    output Trig, Gate, Done, TimeoutErr, Busy
  );
endinterface

// File: rtl/telemetre_trigger_echo_sync.sv
// Two-flop synchroniser for an asynchronous input plus rise/fall detection
// on the synchronised level; reusable for buttons and other async inputs.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;

endmodule

// File: rtl/telemetre_trigger.sv
// Ultrasonic range-finder sequencer: periodic trigger pulse, echo
// qualification into a Gate window, and missing/stuck echo timeout.
module telemetre_trigger
  import telemetre_trigger_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input logic              Clk,
  input logic              Reset,
  telemetre_trigger_if.slave bus
);

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT   = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_n;
  logic [CNT_W-1:0] pcnt, tcnt;
  logic             pcnt_clr, tcnt_clr, timed_out;
  logic             echo_s, echo_rise, echo_fall;
  logic             trig_q, gate_q, done_q, err_q, busy_q;
  logic             trig_n, gate_n, done_n, err_n;

  echo_sync u_echo_sync (
    .clk   (Clk),
    .rst   (Reset),
    .din   (bus.Echo),
    .level (echo_s),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  assign timed_out = (tcnt >= TMO_LIMIT);

  // MEASURE is only entered on a rise and left as soon as echo_s drops,
  // so inside it "echo_s == 0" is exactly the detected fall.
  always_comb begin
    state_n  = state;
    trig_n   = 1'b0;
    gate_n   = 1'b0;
    done_n   = 1'b0;
    err_n    = err_q;
    pcnt_clr = 1'b0;
    tcnt_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Enable) begin
          state_n  = ST_TRIG;
          trig_n   = 1'b1;
          err_n    = 1'b0;
          pcnt_clr = 1'b1;
        end
      end
      ST_TRIG: begin
        if (pcnt >= TRIG_LAST) begin
          state_n  = ST_WAIT_RISE;
          tcnt_clr = 1'b1;
        end else begin
          trig_n = 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        if (timed_out) begin
          state_n = ST_HOLDOFF;
          err_n   = 1'b1;
        end else if (echo_rise) begin
          state_n = ST_MEASURE;
          gate_n  = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (echo_fall) begin
          state_n = ST_HOLDOFF;
          done_n  = 1'b1;
        end else if (timed_out) begin
          state_n = ST_HOLDOFF;
          err_n   = 1'b1;
        end else begin
          gate_n = echo_s;
        end
      end
      ST_HOLDOFF: begin
        if (pcnt >= PERIOD_LAST) begin
          if (bus.Enable) begin
            state_n  = ST_TRIG;
            trig_n   = 1'b1;
            err_n    = 1'b0;
            pcnt_clr = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= ST_IDLE;
      trig_q <= 1'b0;
      gate_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      trig_q <= trig_n;
      gate_q <= gate_n;
      done_q <= done_n;
      err_q  <= err_n;
      busy_q <= (state_n != ST_IDLE);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pcnt <= '0;
      tcnt <= '0;
    end else begin
      if (pcnt_clr)
        pcnt <= '0;
      else if (state != ST_IDLE && pcnt != '1)
        pcnt <= pcnt + CNT_W'(1);

      if (tcnt_clr)
        tcnt <= '0;
      else if ((state == ST_WAIT_RISE || state == ST_MEASURE) && tcnt != '1)
        tcnt <= tcnt + CNT_W'(1);
    end
  end

  assign bus.Trig       = trig_q;
  assign bus.Gate       = gate_q;
  assign bus.Done       = done_q;
  assign bus.TimeoutErr = err_q;
  assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_telemetre_trigger.sv
// Directed bench for telemetre_trigger: expected output edges are queued with
// their cycle numbers as stimulus is applied and matched as the DUT toggles.
module tb_telemetre_trigger;

  localparam int unsigned S_TRIG = 0;
  localparam int unsigned S_GATE = 1;
  localparam int unsigned S_DONE = 2;
  localparam int unsigned S_ERR  = 3;
  localparam int unsigned S_BUSY = 4;

  typedef struct {
    int unsigned sig;
    int unsigned cyc;
  } ev_t;

  logic Clk = 1'b0;
  logic Reset;

  telemetre_trigger_if bus ();

  telemetre_trigger #(
    .TRIG_CYCLES    (5),
    .PERIOD_CYCLES  (100),
    .TIMEOUT_CYCLES (60),
    .CNT_W          (8)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc++;

  int   nchecks = 0;
  int   nerrs   = 0;
  ev_t  sb[$];
  logic mon_en  = 1'b0;
  logic [4:0] cur, prev;

  function automatic string sig_name(input int unsigned s);
    case (s)
      S_TRIG:  return "Trig";
      S_GATE:  return "Gate";
      S_DONE:  return "Done";
      S_ERR:   return "TimeoutErr";
      default: return "Busy";
    endcase
  endfunction

  task automatic push(input int unsigned s, input int unsigned c);
    ev_t e;
    e.sig = s;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic sb_edge(input int unsigned s, input int unsigned c);
    int          idx;
    logic        found;
    int unsigned exp_c;
    idx = -1;
    foreach (sb[i]) if (idx < 0 && sb[i].sig == s) idx = i;
    found = (idx >= 0);
    exp_c = found ? sb[idx].cyc : 0;
    nchecks++;
    assert (found && c === exp_c) else begin
      nerrs++;
      $error("FAIL edge_%s: toggled at cycle %0d, expected %s", sig_name(s), c,
             found ? $sformatf("cycle %0d", exp_c) : "no toggle");
    end
    if (found) sb.delete(idx);
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    nchecks++;
    assert (got === exp) else begin
      nerrs++;
      $error("FAIL %s: observed %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge Clk);
  endtask

  // Edge monitor: every output toggle must match the oldest queued one.
  always @(negedge Clk) begin
    if (mon_en) begin
      cur = {bus.Busy, bus.TimeoutErr, bus.Done, bus.Gate, bus.Trig};
      for (int unsigned s = 0; s < 5; s++)
        if (cur[s] !== prev[s]) sb_edge(s, cyc);
      prev = cur;
    end
  end

  int unsigned t, r1, r2, r3, r4, r5;

  initial begin
    Reset      = 1'b1;
    bus.Enable = 1'b0;
    bus.Echo   = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    chk("rst_trig", bus.Trig, 1'b0);
    chk("rst_gate", bus.Gate, 1'b0);
    chk("rst_done", bus.Done, 1'b0);
    chk("rst_err",  bus.TimeoutErr, 1'b0);
    chk("rst_busy", bus.Busy, 1'b0);
    prev   = '0;
    mon_en = 1'b1;

    // Cycle 1: valid 20-cycle echo starting 10 cycles after Trig falls.
    t = cyc;
    bus.Enable = 1'b1;
    r1 = t + 1;
    push(S_BUSY, r1);
    push(S_TRIG, r1);
    push(S_TRIG, r1 + 5);
    push(S_TRIG, r1 + 100);
    wait_until(r1 + 15);
    bus.Echo = 1'b1;
    push(S_GATE, r1 + 18);
    wait_until(r1 + 35);
    bus.Echo = 1'b0;
    push(S_GATE, r1 + 38);
    push(S_DONE, r1 + 38);
    push(S_DONE, r1 + 39);

    // Cycle 2: no echo, timeout 61 cycles after Trig falls.
    r2 = r1 + 100;
    wait_until(r2 + 1);
    push(S_TRIG, r2 + 5);
    push(S_ERR,  r2 + 66);
    push(S_ERR,  r2 + 100);
    push(S_TRIG, r2 + 100);

    // Cycle 3: echo stuck high before the trigger.
    wait_until(r2 + 80);
    bus.Echo = 1'b1;
    r3 = r2 + 100;
    wait_until(r3 + 1);
    push(S_TRIG, r3 + 5);
    push(S_ERR,  r3 + 66);
    push(S_ERR,  r3 + 100);
    push(S_TRIG, r3 + 100);
    wait_until(r3 + 80);
    bus.Echo = 1'b0;

    // Cycle 4: 80-cycle echo, Gate cut at the timeout with no Done.
    r4 = r3 + 100;
    wait_until(r4 + 1);
    push(S_TRIG, r4 + 5);
    wait_until(r4 + 15);
    bus.Echo = 1'b1;
    push(S_GATE, r4 + 18);
    push(S_GATE, r4 + 66);
    push(S_ERR,  r4 + 66);
    push(S_ERR,  r4 + 100);
    push(S_TRIG, r4 + 100);
    wait_until(r4 + 95);
    bus.Echo = 1'b0;

    // Cycle 5: Enable dropped during MEASURE; window completes, then idle.
    r5 = r4 + 100;
    wait_until(r5 + 1);
    push(S_TRIG, r5 + 5);
    wait_until(r5 + 15);
    bus.Echo = 1'b1;
    push(S_GATE, r5 + 18);
    wait_until(r5 + 25);
    bus.Enable = 1'b0;
    wait_until(r5 + 35);
    bus.Echo = 1'b0;
    push(S_GATE, r5 + 38);
    push(S_DONE, r5 + 38);
    push(S_DONE, r5 + 39);
    push(S_BUSY, r5 + 100);
    wait_until(r5 + 130);
    chk("idle_busy", bus.Busy, 1'b0);
    chk("idle_trig", bus.Trig, 1'b0);

    nchecks++;
    assert (sb.size() === 0) else begin
      nerrs++;
      $error("FAIL sb_empty: %0d expected toggles never seen, expected 0", sb.size());
      foreach (sb[i])
        $display("  missing %s toggle at cycle %0d", sig_name(sb[i].sig), sb[i].cyc);
    end
    sb.delete();

    // Asynchronous reset in the middle of TRIG.
    mon_en = 1'b0;
    t = cyc;
    bus.Enable = 1'b1;
    wait_until(t + 3);
    chk("pre_rst_trig", bus.Trig, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_trig", bus.Trig, 1'b0);
    chk("async_rst_gate", bus.Gate, 1'b0);
    chk("async_rst_busy", bus.Busy, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_trig", bus.Trig, 1'b1);
    chk("post_rst_busy", bus.Busy, 1'b1);
    repeat (2) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
